fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the 6-bit program counter and drives the memory address. The memory returns the 23-bit instruction word combinationally in the same cycle; this block registers it together with its PC and presents both to decode over a valid/ready handshake. It also supports start/halt control, a branch redirect with flush, and automatic halt at a programmable last address.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives instruction memory, registers the word for decode.
// Latency: 1 cycle from pc/im_addr to instr_out; 1 instruction/cycle while instr_ready is high.
// Backpressure: instr_valid && !instr_ready holds pc and outputs; a redirect still flushes the held word.
module fetch_unit #(
  parameter int                ADDR_W    = 6,
  parameter int                INSTR_W   = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_code,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              can_load;
  logic              xfer;

  // Output register is free when empty or being drained this cycle.
  assign can_load = !instr_valid || instr_ready;
  assign xfer     = instr_valid && instr_ready;

  // Memory is addressed straight from the PC in every state.
  assign im_addr = pc;
  assign busy    = (state == FETCH);
  assign state_o = state;

  // Fetch FSM: PC, output register and state updated together; redirect > halt > fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      // A completed handshake empties the register unless a capture refills it below.
      if (xfer) begin
        instr_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          if (redirect_en) begin
            // Flush discards the buffered word even if decode never took it.
            pc          <= redirect_addr;
            instr_valid <= 1'b0;
          end else if (halt_req) begin
            state <= HALTED;
          end else if (can_load) begin
            instr_out   <= im_code;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
            if (pc == LAST_ADDR) begin
              state <= HALTED;
            end
          end
        end

        HALTED: begin
          // Redirect while halted only repositions the PC; a later start resumes there.
          if (redirect_en) begin
            pc          <= redirect_addr;
            instr_valid <= 1'b0;
          end else if (start) begin
            state <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, halt_req, redirect_en, instr_ready;
  logic [5:0]  redirect_addr;
  logic [22:0] mem [64];

  logic [5:0]  im_addr_a, im_addr_b, instr_pc_a, instr_pc_b;
  logic [22:0] im_code_a, im_code_b, instr_out_a, instr_out_b;
  logic        instr_valid_a, instr_valid_b, busy_a, busy_b;
  logic [1:0]  state_a, state_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign im_code_a = mem[im_addr_a];
  assign im_code_b = mem[im_addr_b];

  fetch_unit #(.ADDR_W(6), .INSTR_W(23), .LAST_ADDR(6'h3F)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .im_addr(im_addr_a), .im_code(im_code_a),
    .instr_out(instr_out_a), .instr_pc(instr_pc_a), .instr_valid(instr_valid_a),
    .instr_ready(instr_ready), .busy(busy_a), .state_o(state_a)
  );

  fetch_unit #(.ADDR_W(6), .INSTR_W(23), .LAST_ADDR(6'h04)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .im_addr(im_addr_b), .im_code(im_code_b),
    .instr_out(instr_out_b), .instr_pc(instr_pc_b), .instr_valid(instr_valid_b),
    .instr_ready(instr_ready), .busy(busy_b), .state_o(state_b)
  );

  // Reference model: mode 0=idle 1=running 2=halted, plain integer PC.
  typedef struct {
    int mode;
    int pc;
    bit vld;
    int ipc;
    int iout;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_next(mdl_t m, int last, bit rn, bit st, bit hl,
                                    bit rd, int ra, bit rdy);
    mdl_t n;
    n = m;
    if (!rn) begin
      n.mode = 0; n.pc = 0; n.vld = 1'b0; n.ipc = 0; n.iout = 0;
      return n;
    end
    if (m.vld && rdy) n.vld = 1'b0;
    if (m.mode == 0) begin
      if (st) n.mode = 1;
    end else if (m.mode == 1) begin
      if (rd) begin
        n.pc = ra; n.vld = 1'b0;
      end else if (hl) begin
        n.mode = 2;
      end else if (!m.vld || rdy) begin
        n.iout = int'(mem[m.pc]);
        n.ipc  = m.pc;
        n.vld  = 1'b1;
        n.pc   = (m.pc + 1) % 64;
        if (m.pc == last) n.mode = 2;
      end
    end else begin
      if (rd) begin
        n.pc = ra; n.vld = 1'b0;
      end else if (st) begin
        n.mode = 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("a.state", int'(state_a), ma.mode);
    chk("a.busy", int'(busy_a), int'(ma.mode == 1));
    chk("a.im_addr", int'(im_addr_a), ma.pc);
    chk("a.valid", int'(instr_valid_a), int'(ma.vld));
    chk("a.instr_pc", int'(instr_pc_a), ma.ipc);
    chk("a.instr_out", int'(instr_out_a), ma.iout);
    chk("b.state", int'(state_b), mb.mode);
    chk("b.busy", int'(busy_b), int'(mb.mode == 1));
    chk("b.im_addr", int'(im_addr_b), mb.pc);
    chk("b.valid", int'(instr_valid_b), int'(mb.vld));
    chk("b.instr_pc", int'(instr_pc_b), mb.ipc);
    chk("b.instr_out", int'(instr_out_b), mb.iout);
  endtask

  // Drive one cycle of inputs, advance both models, clock, then compare.
  task automatic step(input bit rn, input bit st, input bit hl, input bit rd,
                      input logic [5:0] ra, input bit rdy);
    rst_n = rn; start = st; halt_req = hl; redirect_en = rd;
    redirect_addr = ra; instr_ready = rdy;
    ma = mdl_next(ma, 63, rn, st, hl, rd, int'(ra), rdy);
    mb = mdl_next(mb, 4, rn, st, hl, rd, int'(ra), rdy);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit         rn, st, hl, rd;
    logic [5:0] ra;
    bit         rdy;
    int         e_st;
    bit         e_vld;
    int         e_ipc;
    int         e_iout;
    int         e_ima;
  } vec_t;

  vec_t tbl [27];

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_en = 1'b0;
    redirect_addr = '0; instr_ready = 1'b0;
    ma = '{0, 0, 1'b0, 0, 0};
    mb = '{0, 0, 1'b0, 0, 0};
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 23'h000000; mem[1] = 23'h000001; mem[2] = 23'h000002;
    mem[3] = 23'h000020; mem[4] = 23'h000050;
    mem[62] = 23'h012345; mem[63] = 23'h7ABCDE;

    // Expectations below are for the LAST_ADDR=3F instance.
    //          rn st hl rd ra     rdy  st vld ipc   iout        ima
    tbl[0]  = '{0, 0, 0, 0, 6'h00, 0,   0, 0,  0,    0,          0};
    tbl[1]  = '{1, 0, 1, 1, 6'h09, 1,   0, 0,  0,    0,          0};
    tbl[2]  = '{1, 1, 0, 0, 6'h00, 1,   1, 0,  0,    0,          0};
    tbl[3]  = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  0,    0,          1};
    tbl[4]  = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  1,    1,          2};
    tbl[5]  = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  2,    2,          3};
    tbl[6]  = '{1, 0, 0, 0, 6'h00, 0,   1, 1,  2,    2,          3};
    tbl[7]  = '{1, 0, 0, 0, 6'h00, 0,   1, 1,  2,    2,          3};
    tbl[8]  = '{1, 0, 0, 0, 6'h00, 0,   1, 1,  2,    2,          3};
    tbl[9]  = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  3,    'h20,       4};
    tbl[10] = '{1, 0, 0, 1, 6'h01, 0,   1, 0,  3,    'h20,       1};
    tbl[11] = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  1,    1,          2};
    tbl[12] = '{1, 1, 1, 0, 6'h00, 0,   2, 1,  1,    1,          2};
    tbl[13] = '{1, 0, 0, 0, 6'h00, 1,   2, 0,  1,    1,          2};
    tbl[14] = '{1, 1, 0, 0, 6'h00, 1,   1, 0,  1,    1,          2};
    tbl[15] = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  2,    2,          3};
    tbl[16] = '{0, 0, 0, 0, 6'h00, 0,   0, 0,  0,    0,          0};
    tbl[17] = '{1, 0, 0, 0, 6'h00, 1,   0, 0,  0,    0,          0};
    tbl[18] = '{1, 1, 0, 0, 6'h00, 1,   1, 0,  0,    0,          0};
    tbl[19] = '{1, 0, 0, 1, 6'h3E, 1,   1, 0,  0,    0,          'h3E};
    tbl[20] = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  'h3E, 'h12345,    'h3F};
    tbl[21] = '{1, 0, 0, 0, 6'h00, 1,   2, 1,  'h3F, 'h7ABCDE,   0};
    tbl[22] = '{1, 0, 0, 0, 6'h00, 1,   2, 0,  'h3F, 'h7ABCDE,   0};
    tbl[23] = '{1, 1, 0, 0, 6'h00, 1,   1, 0,  'h3F, 'h7ABCDE,   0};
    tbl[24] = '{1, 0, 0, 0, 6'h00, 1,   1, 1,  0,    0,          1};
    tbl[25] = '{1, 0, 1, 0, 6'h00, 1,   2, 0,  0,    0,          1};
    tbl[26] = '{1, 0, 0, 1, 6'h07, 0,   2, 0,  0,    0,          7};

    @(posedge clk);
    #1;
    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rn, tbl[i].st, tbl[i].hl, tbl[i].rd, tbl[i].ra, tbl[i].rdy);
      chk($sformatf("tbl%0d.state", i), int'(state_a), tbl[i].e_st);
      chk($sformatf("tbl%0d.valid", i), int'(instr_valid_a), int'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.instr_pc", i), int'(instr_pc_a), tbl[i].e_ipc);
      chk($sformatf("tbl%0d.instr_out", i), int'(instr_out_a), tbl[i].e_iout);
      chk($sformatf("tbl%0d.im_addr", i), int'(im_addr_a), tbl[i].e_ima);
    end

    // Streaming from 0 on both instances; LAST_ADDR=4 instance halts after pc 4.
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
      chk("seq.a.valid", int'(instr_valid_a), 1);
      chk("seq.a.instr_pc", int'(instr_pc_a), i);
      chk("seq.a.instr_out", int'(instr_out_a), int'(mem[i]));
      chk("seq.b.instr_pc", int'(instr_pc_b), i);
    end
    chk("seq.a.im_addr", int'(im_addr_a), 5);
    chk("last.b.state", int'(state_b), 2);
    chk("last.b.busy", int'(busy_b), 0);
    chk("last.b.im_addr", int'(im_addr_b), 5);
    chk("last.b.instr_out", int'(instr_out_b), 'h50);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
      chk("last.b.nocapture_pc", int'(instr_pc_b), 4);
      chk("last.b.nocapture_vld", int'(instr_valid_b), 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1);
    chk("resume.b.state", int'(state_b), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    chk("resume.b.instr_pc", int'(instr_pc_b), 5);
    chk("resume.b.instr_out", int'(instr_out_b), 0);
    chk("resume.b.valid", int'(instr_valid_b), 1);

    // Randomized run against the model on both instances.
    for (int i = 0; i < 64; i++) mem[i] = 23'($urandom);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(4) == 0,
           $urandom_range(9) == 0,
           $urandom_range(9) == 0,
           6'($urandom),
           $urandom_range(9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
